axi4lite_read_pipe: RTL and testbench
=====================================

Name: axi4lite_read_pipe

Overview:
- Parametrised AXI4-Lite read slave for the FIR configuration space.
- Replaces the single-transaction read FSM. Accepts up to pAR_DEPTH queued read addresses and keeps several reads in flight to a fixed-latency config read port.
- Buffers responses in an R FIFO, returns RRESP, and flags out-of-range or misaligned addresses with SLVERR.
- Sits between the AXI4-Lite slave interface and the FIR register/tap-RAM read mux.

Parameters:
- pADDR_WIDTH, 12, AXI read address width.
- pDATA_WIDTH, 32, read data width.
- pADDR_LIMIT, 12'h100, first illegal byte address; araddr >= limit gives SLVERR.
- pAR_DEPTH, 2, address queue entries (>=1, power of two).
- pR_DEPTH, 4, response FIFO entries; also the in-flight credit limit (power of two).
- pRD_LAT, 1, config read latency in cycles (>=1).

Ports:
- axis_clk  in  1  sole clock; all state on posedge.
- axis_rst_n  in  1  asynchronous active-low reset.
- araddr  in  pADDR_WIDTH  read address.
- arvalid  in  1  address valid.
- arready  out  1  address ready.
- rdata  out  pDATA_WIDTH  read data.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rvalid  out  1  response valid.
- rready  in  1  response ready.
- cfg_rd_en  out  1  one-cycle read strobe to config space.
- cfg_rd_addr  out  pADDR_WIDTH  config read address, valid when cfg_rd_en=1.
- cfg_rd_data  in  pDATA_WIDTH  valid exactly pRD_LAT cycles after cfg_rd_en.
- rd_busy  out  1  high if any queue, pipeline or FIFO is non-empty.

Behaviour:
- Single clock, asynchronous active-low reset.
- Reset:
  - All queues and pipes empty, pointers and counters 0.
  - Outputs: arready=0 while axis_rst_n=0, then 1 from the first post-reset cycle; rvalid=0, cfg_rd_en=0, rdata=0, rresp=0, rd_busy=0.
- AR channel:
  - arready = !ar_full.
  - Handshake is arvalid&arready at a posedge. It pushes araddr plus an err bit: err = (araddr >= pADDR_LIMIT) | (araddr[1:0] != 0).
  - No combinational path from arvalid to arready.
- Issue:
  - Fires when the AR queue is not empty and credit is available: inflight + r_count < pR_DEPTH.
  - On issue the head is popped and an entry enters the pRD_LAT-deep valid/err shift pipe.
  - cfg_rd_en = issue & !err; cfg_rd_addr = head address.
  - Error entries never strobe cfg_rd_en but still occupy a pipe slot, so response order is preserved.
  - At most one issue per cycle.
- Return:
  - When the pipe tail is valid, the R FIFO is pushed with {cfg_rd_data, 00}, or {0, 10} for an error entry.
  - Credit makes overflow impossible; an overflow is an assertion failure.
- R channel:
  - rvalid = !r_empty; rdata/rresp come from the FIFO head.
  - Pop on rvalid&rready.
  - Once rvalid is high, the presented data must not change until the pop.
  - Push and pop in the same cycle keep r_count unchanged.
- Latency:
  - AR handshake at edge 0 → cfg_rd_en in cycle 1 → rvalid in cycle 2+pRD_LAT (3 for default) when the FIFO was empty.
  - Throughput is one read per cycle while rready=1.
- Boundaries:
  - AR queue full: arready=0; an AR push and an issue pop in the same cycle are allowed.
  - Credits exhausted (rready held low): issue stalls and the AR queue fills. Resumption resumes without loss or reordering.
  - Pointers wrap modulo depth; full/empty come from counters.
  - Reset asserted mid-operation discards all pending transactions immediately. Late cfg_rd_data is ignored.

Decomposition:
- Package axi4lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and a log2 helper function.
- One sub-module, sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count, same clock/reset), instantiated twice:
  - AR queue, width pADDR_WIDTH+1.
  - R FIFO, width pDATA_WIDTH+2.
- Issue/credit logic and the latency pipe stay in the top.

Test Plan:
- Single read: after reset, read 0x010 with cfg model returning 0x0000_0032 → cfg_rd_en one cycle with addr 0x010; rvalid at cycle 3 with rdata=0x32, rresp=00.
- Back-to-back: 4 reads 0x000,0x004,0x008,0x00C in consecutive cycles, rready=1 → responses in order, one per cycle, no bubbles after the first.
- Backpressure: rready=0, 8 reads offered → 4 responses buffered, issue stalls, arready drops after 6 accepts. Then rready=1 → all 8 returned in order, rvalid data stable while stalled.
- Errors: reads at 0x100 and 0x006 between two legal reads → no cfg_rd_en for the bad ones; rresp=10 with rdata=0 in positions 2 and 3; legal reads give OKAY.
- Latency sweep: pRD_LAT=3, pR_DEPTH=2, reads streamed → never more than 2 in flight plus buffered; data matches the address-derived model.
- Reset mid-stream: assert axis_rst_n=0 with 3 reads in flight → rvalid=0 and rd_busy=0 immediately. After release, arready=1, and a new read returns correct data with no stale response.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared definitions for the FIR configuration-space read path.
//   RESP_OKAY / RESP_SLVERR : AXI4-Lite RRESP encodings used by the read slave.
//   log2()                  : ceiling log2, used to size pointers and counters.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Ceiling log2; log2(1) = 0, log2(4) = 2, log2(5) = 3.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi4lite_read_pipe_if.sv
// AXI4-Lite read channels (AR and R) between a bus master and the read slave.
//   araddr/arvalid/arready : read address channel
//   rdata/rresp/rvalid/rready : read response channel
// Handshake: a beat transfers on a posedge where valid and ready are both high.
// Once valid is raised, the payload is held stable until that transfer edge;
// ready never depends combinationally on valid.
interface axi4lite_read_pipe_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   arvalid;
  logic                   arready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;

  modport master (output araddr, arvalid, rready,
                  input  arready, rdata, rresp, rvalid);
  modport slave  (input  araddr, arvalid, rready,
                  output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   push/wdata : write when push=1 and not full
//   pop/rdata  : rdata shows the head; pop removes it when not empty
//   full/empty/count : status derived from the occupancy counter
module sync_fifo
  import axi4lite_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = log2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = (DEPTH > 1) ? log2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: empty/count gate every use of the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/axi4lite_read_pipe.sv
// Pipelined AXI4-Lite read slave for the FIR configuration space.
//   axis_clk, axis_rst_n : clock, asynchronous active-low reset
//   s_axi                : AR/R channels (slave modport)
//   cfg_rd_en/addr       : one-cycle read strobe and address to config space
//   cfg_rd_data          : config data, valid pRD_LAT cycles after cfg_rd_en
//   rd_busy              : any address, in-flight read or response pending
// Addresses queue in an AR FIFO, issue one per cycle while response credit
// remains, travel down a pRD_LAT-deep valid/err pipe and land in an R FIFO.
// Illegal (out-of-range or misaligned) reads take a pipe slot without
// strobing config space, so responses stay in request order.
module axi4lite_read_pipe
  import axi4lite_pkg::*;
#(
  parameter int                     pADDR_WIDTH = 12,
  parameter int                     pDATA_WIDTH = 32,
  parameter logic [pADDR_WIDTH-1:0] pADDR_LIMIT = 'h100,
  parameter int                     pAR_DEPTH   = 2,
  parameter int                     pR_DEPTH    = 4,
  parameter int                     pRD_LAT     = 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  axi4lite_read_pipe_if.slave    s_axi,
  output logic                   cfg_rd_en,
  output logic [pADDR_WIDTH-1:0] cfg_rd_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_rd_data,
  output logic                   rd_busy
);
  localparam int ARW = pADDR_WIDTH + 1;
  localparam int RW  = pDATA_WIDTH + 2;
  localparam int ACW = log2(pAR_DEPTH + 1);
  localparam int RCW = log2(pR_DEPTH + 1);
  localparam int IW  = log2(pRD_LAT + 1);

  logic             ready_q;
  logic [ARW-1:0]   ar_wdata, ar_rdata;
  logic             ar_push, ar_full, ar_empty;
  logic [ACW-1:0]   ar_count;
  logic             head_err, issue;
  logic [pRD_LAT-1:0] pv_q, pe_q;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic             tail_v, tail_e;
  logic [RW-1:0]    r_wdata, r_rdata;
  logic             r_pop, r_full, r_empty;
  logic [RCW-1:0]   r_count;

  // ready_q holds arready low while in reset and releases it one edge later.
  assign s_axi.arready = ready_q & ~ar_full;
  assign ar_push       = s_axi.arvalid & s_axi.arready;
  assign ar_wdata      = {(s_axi.araddr >= pADDR_LIMIT) | (s_axi.araddr[1:0] != 2'b00),
                          s_axi.araddr};

  sync_fifo #(.WIDTH(ARW), .DEPTH(pAR_DEPTH)) u_ar_q (
    .clk(axis_clk), .rst_n(axis_rst_n),
    .push(ar_push), .wdata(ar_wdata), .pop(issue), .rdata(ar_rdata),
    .full(ar_full), .empty(ar_empty), .count(ar_count)
  );

  // Credit: every read in the pipe or buffered in the R FIFO owns one FIFO
  // slot, so the FIFO can never be pushed while full.
  assign head_err    = ar_rdata[pADDR_WIDTH];
  assign issue       = ~ar_empty & ((int'(inflight_q) + int'(r_count)) < pR_DEPTH);
  assign cfg_rd_en   = issue & ~head_err;
  assign cfg_rd_addr = ar_rdata[pADDR_WIDTH-1:0];

  assign tail_v = pv_q[pRD_LAT-1];
  assign tail_e = pe_q[pRD_LAT-1];

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, tail_v})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ready_q    <= 1'b0;
      pv_q       <= '0;
      pe_q       <= '0;
      inflight_q <= '0;
    end else begin
      ready_q    <= 1'b1;
      pv_q[0]    <= issue;
      pe_q[0]    <= issue & head_err;
      for (int i = 1; i < pRD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
      inflight_q <= inflight_d;
    end
  end

  // The pipe tail lines up with cfg_rd_data of the matching strobe.
  assign r_wdata = tail_e ? {{pDATA_WIDTH{1'b0}}, RESP_SLVERR}
                          : {cfg_rd_data, RESP_OKAY};
  assign r_pop   = ~r_empty & s_axi.rready;

  sync_fifo #(.WIDTH(RW), .DEPTH(pR_DEPTH)) u_r_fifo (
    .clk(axis_clk), .rst_n(axis_rst_n),
    .push(tail_v), .wdata(r_wdata), .pop(r_pop), .rdata(r_rdata),
    .full(r_full), .empty(r_empty), .count(r_count)
  );

  // Outputs forced to zero when empty so reset shows rdata=0, rresp=OKAY.
  assign s_axi.rvalid = ~r_empty;
  assign s_axi.rdata  = r_empty ? '0 : r_rdata[RW-1:2];
  assign s_axi.rresp  = r_empty ? RESP_OKAY : r_rdata[1:0];

  assign rd_busy = (ar_count != '0) | (inflight_q != '0) | ~r_empty;

  r_fifo_no_overflow : assert property (
    @(posedge axis_clk) disable iff (!axis_rst_n) !(tail_v && r_full));

endmodule

// File: tb/tb_axi4lite_read_pipe.sv
module tb_axi4lite_read_pipe;
  import axi4lite_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1: default parameters ----------------
  axi4lite_read_pipe_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();
  logic        cfg_en;
  logic [11:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        busy;

  axi4lite_read_pipe dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .s_axi(bus),
    .cfg_rd_en(cfg_en), .cfg_rd_addr(cfg_addr), .cfg_rd_data(cfg_data),
    .rd_busy(busy)
  );

  // ---------------- DUT 2: pRD_LAT=3, pR_DEPTH=2 ----------------
  axi4lite_read_pipe_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus2 ();
  logic        cfg_en2;
  logic [11:0] cfg_addr2;
  logic [31:0] cfg_data2;
  logic        busy2;

  axi4lite_read_pipe #(.pRD_LAT(3), .pR_DEPTH(2)) dut2 (
    .axis_clk(clk), .axis_rst_n(rst_n), .s_axi(bus2),
    .cfg_rd_en(cfg_en2), .cfg_rd_addr(cfg_addr2), .cfg_rd_data(cfg_data2),
    .rd_busy(busy2)
  );

  // Config-space model: data = addr*3 + 2, filler value when not addressed.
  function automatic logic [31:0] model(input logic [11:0] a);
    return {20'd0, a} * 32'd3 + 32'd2;
  endfunction

  always @(posedge clk) cfg_data <= cfg_en ? model(cfg_addr) : 32'hDEAD_BEEF;

  logic [31:0] d2a, d2b;
  always @(posedge clk) begin
    d2a       <= cfg_en2 ? model(cfg_addr2) : 32'hDEAD_BEEF;
    d2b       <= d2a;
    cfg_data2 <= d2b;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic [11:0] addr_q[$];
  int          pop_cyc_q[$];
  int          strobes = 0;
  logic        hold = 1'b0;
  logic [33:0] held;

  logic [33:0] exp_q2[$];
  int          strobes2 = 0;
  int          pops2 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- DUT 1 monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold) begin
        chk("r_stable_valid", bus.rvalid, 1);
        chk("r_stable_data", {bus.rdata, bus.rresp}, held);
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual=%0h required=no_response", {bus.rdata, bus.rresp});
        end else begin
          chk("r_data_resp", {bus.rdata, bus.rresp}, exp_q.pop_front());
          pop_cyc_q.push_back(cyc);
        end
      end
      hold = bus.rvalid && !bus.rready;
      held = {bus.rdata, bus.rresp};
      if (cfg_en) begin
        strobes++;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cfg_unexpected actual=%0h required=no_strobe", cfg_addr);
        end else chk("cfg_addr", cfg_addr, addr_q.pop_front());
      end
    end else hold = 1'b0;
  end

  // ---------------- DUT 2 monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_en2) begin
        strobes2++;
        chk("lat3_credit", (strobes2 - pops2) <= 2, 1);
      end
      if (bus2.rvalid && bus2.rready) begin
        pops2++;
        if (exp_q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL lat3_unexpected actual=%0h required=no_response", bus2.rdata);
        end else chk("lat3_data", {bus2.rdata, bus2.rresp}, exp_q2.pop_front());
      end
    end
  end

  initial begin
    bus2.rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus2.rready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [11:0] a, input logic [33:0] e);
    int n;
    n = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin step(); n++; end
    if (!bus.arready) begin
      checks++; errors++;
      $display("FAIL ar_timeout actual=stalled required=accept addr=%0h", a);
      bus.arvalid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    if (e[1:0] == RESP_OKAY) addr_q.push_back(a);
    step();
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin step(); n++; end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;
  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int sb, n, ok_cnt;
    vecs[0]  = '{12'h010, 32'h0000_0032, 2'b00};
    vecs[1]  = '{12'h000, 32'h0000_0002, 2'b00};
    vecs[2]  = '{12'h004, 32'h0000_000E, 2'b00};
    vecs[3]  = '{12'h008, 32'h0000_001A, 2'b00};
    vecs[4]  = '{12'h00C, 32'h0000_0026, 2'b00};
    vecs[5]  = '{12'h020, 32'h0000_0062, 2'b00};
    vecs[6]  = '{12'h100, 32'h0000_0000, 2'b10};
    vecs[7]  = '{12'h006, 32'h0000_0000, 2'b10};
    vecs[8]  = '{12'h024, 32'h0000_006E, 2'b00};
    vecs[9]  = '{12'h0FC, 32'h0000_02F6, 2'b00};
    vecs[10] = '{12'h0FD, 32'h0000_0000, 2'b10};
    vecs[11] = '{12'hFFC, 32'h0000_0000, 2'b10};
    vecs[12] = '{12'h0FE, 32'h0000_0000, 2'b10};

    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus2.araddr = '0; bus2.arvalid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", bus.arready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_cfg_en", cfg_en, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_arready", bus.arready, 1);

    // Single read: handshake at edge 0, strobe in cycle 1, rvalid in cycle 3
    bus.rready  = 1'b1;
    bus.araddr  = vecs[0].addr;
    bus.arvalid = 1'b1;
    exp_q.push_back({vecs[0].data, vecs[0].resp});
    addr_q.push_back(vecs[0].addr);
    step();
    bus.arvalid = 1'b0;
    chk("single_cfg_en_c1", cfg_en, 1);
    chk("single_rvalid_c1", bus.rvalid, 0);
    step();
    chk("single_cfg_en_c2", cfg_en, 0);
    chk("single_rvalid_c2", bus.rvalid, 0);
    step();
    chk("single_rvalid_c3", bus.rvalid, 1);
    chk("single_rdata_c3", bus.rdata, 32'h32);
    wait_drain("single", 20);

    // Table: back-to-back legal and illegal reads, rready=1
    pop_cyc_q.delete();
    sb = strobes;
    ok_cnt = 0;
    for (int i = 1; i < 13; i++) begin
      if (vecs[i].resp == RESP_OKAY) ok_cnt++;
      send(vecs[i].addr, {vecs[i].data, vecs[i].resp});
    end
    wait_drain("table", 50);
    chk("table_pops", pop_cyc_q.size(), 12);
    for (int i = 1; i < pop_cyc_q.size(); i++)
      chk("table_no_bubble", pop_cyc_q[i] - pop_cyc_q[0], i);
    chk("table_strobes", strobes - sb, ok_cnt);

    // Backpressure: 4 buffered, 2 queued, then arready drops
    bus.rready = 1'b0;
    sb = strobes;
    for (int i = 0; i < 6; i++) send(12'h040 + 12'(4 * i), {model(12'h040 + 12'(4 * i)), RESP_OKAY});
    repeat (3) step();
    chk("bp_arready", bus.arready, 0);
    chk("bp_rvalid", bus.rvalid, 1);
    chk("bp_busy", busy, 1);
    chk("bp_strobes", strobes - sb, 4);
    bus.rready = 1'b1;
    for (int i = 6; i < 8; i++) send(12'h040 + 12'(4 * i), {model(12'h040 + 12'(4 * i)), RESP_OKAY});
    wait_drain("bp", 50);
    chk("bp_all_strobes", strobes - sb, 8);

    // Reset mid-stream with reads in flight
    bus.rready = 1'b0;
    for (int i = 0; i < 3; i++) send(12'h080 + 12'(4 * i), {model(12'h080 + 12'(4 * i)), RESP_OKAY});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.rvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_arready", bus.arready, 0);
    chk("mid_rst_rdata", bus.rdata, 0);
    exp_q.delete();
    addr_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rel_arready", bus.arready, 1);
    chk("rel_rvalid", bus.rvalid, 0);
    bus.rready = 1'b1;
    send(12'h0A0, {model(12'h0A0), RESP_OKAY});
    wait_drain("after_rst", 20);
    repeat (5) step();

    // Latency sweep on DUT 2 with random rready
    for (int i = 0; i < 12; i++) begin
      bus2.araddr  = 12'(4 * i);
      bus2.arvalid = 1'b1;
      n = 0;
      while (!bus2.arready && n < 100) begin step(); n++; end
      if (!bus2.arready) begin
        checks++; errors++;
        $display("FAIL lat3_ar_timeout actual=stalled required=accept");
        break;
      end
      exp_q2.push_back({model(12'(4 * i)), RESP_OKAY});
      step();
    end
    bus2.arvalid = 1'b0;
    n = 0;
    while ((exp_q2.size() != 0 || busy2) && n < 400) begin step(); n++; end
    chk("lat3_left", exp_q2.size(), 0);
    chk("lat3_strobes", strobes2, 12);
    chk("lat3_pops", pops2, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
